nf10_pkt_store: RTL and testbench

Parametrised store-and-forward packet buffer for the nf10 filter datapath. Buffers whole AXI-Stream packets and takes one pass/drop verdict per packet from the filter logic. Only releases a packet downstream once its last beat is stored and its verdict is "pass". Dropped and oversize packets are discarded by rewinding the write pointer and counted; it replaces the fixed 4-entry fall-through input stage.

---
 rtl/nf10_pkt_store_if.sv | 24 ++
 rtl/nf10_pkt_store.sv | 198 +++++++++++++++++++
 tb/tb_nf10_pkt_store.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf10_pkt_store_if.sv
// rtl/nf10_pkt_store_if.sv - AXI-Stream beat bundle used on both sides of nf10_pkt_store
//
// Signals:
//   tdata  [DATA_W-1:0]    beat payload
//   tstrb  [DATA_W/8-1:0]  byte qualifiers
//   tuser  [USER_W-1:0]    per-beat sideband, carried through unchanged
//   tvalid                 source has a beat
//   tlast                  beat closes the packet
//   tready                 sink takes the beat
// Modports: master drives the beat and samples tready; slave is the mirror.
interface nf10_pkt_store_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input  tready);
    modport slave  (input  tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_pkt_store.sv
// rtl/nf10_pkt_store.sv - store-and-forward packet buffer with per-packet pass/drop verdict
//
// Ports:
//   axi_aclk        clock, rising edge
//   axi_aresetn     asynchronous active-low reset
//   s_axis          upstream stream (slave modport); tready is driven here
//   m_axis          downstream stream (master modport); only committed beats appear
//   verdict_valid   one-cycle strobe, one per packet
//   verdict_pass    1 = forward the packet, 0 = drop it; sampled with verdict_valid
//   pass_count      packets committed, wraps
//   drop_count      packets dropped by verdict or for being too large, wraps
//
// Beats are written at wr_ptr as they arrive. A packet becomes visible downstream only
// when commit_ptr is advanced to wr_ptr after its last beat and a pass verdict; a drop
// rewinds wr_ptr to commit_ptr. The read side runs from rd_ptr up to commit_ptr.
module nf10_pkt_store #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int DEPTH_BITS           = 6,
    parameter int VERDICT_EN           = 1
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    nf10_pkt_store_if.slave       s_axis,
    nf10_pkt_store_if.master      m_axis,
    input  logic                  verdict_valid,
    input  logic                  verdict_pass,
    output logic [31:0]           pass_count,
    output logic [31:0]           drop_count
);

    localparam int DW    = C_M_AXIS_DATA_WIDTH;
    localparam int UW    = C_M_AXIS_TUSER_WIDTH;
    localparam int SW    = DW / 8;
    localparam int MW    = 1 + UW + SW + DW;
    localparam int DEPTH = 1 << DEPTH_BITS;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [DEPTH_BITS:0] ptr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_END,
        S_DISCARD
    } state_t;

    logic [MW-1:0] mem_q [DEPTH];

    state_t      state_q,      state_d;
    ptr_t        wr_ptr_q,     wr_ptr_d;
    ptr_t        commit_ptr_q, commit_ptr_d;
    ptr_t        rd_ptr_q,     rd_ptr_d;
    logic        hv_q,         hv_d;
    logic        hvv_q,        hvv_d;
    logic        fd_q,         fd_d;
    logic [31:0] pass_cnt_q,   pass_cnt_d;
    logic [31:0] drop_cnt_q,   drop_cnt_d;

    logic          full;
    logic          s_ready;
    logic          s_fire;
    logic          wr_en;
    logic          m_valid;
    logic          m_fire;
    logic          v_strobe;
    logic          end_go;
    logic          end_pass;
    logic [MW-1:0] rd_word;

    assign full     = ptr_t'(wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH);
    assign s_ready  = (state_q == S_DISCARD) | ((state_q != S_END) & ~full);
    assign s_fire   = s_axis.tvalid & s_ready;
    // Beats of an oversize packet are swallowed without touching storage.
    assign wr_en    = s_fire & (state_q != S_DISCARD);
    assign m_valid  = rd_ptr_q != commit_ptr_q;
    assign m_fire   = m_valid & m_axis.tready;
    assign v_strobe = (VERDICT_EN != 0) & verdict_valid;

    // END resolves once a verdict is available; a forced drop overrides any verdict.
    always_comb begin
        end_go   = 1'b0;
        end_pass = 1'b0;
        if (VERDICT_EN == 0) begin
            end_go   = 1'b1;
            end_pass = ~fd_q;
        end else begin
            end_go   = hvv_q | v_strobe;
            end_pass = ~fd_q & (hvv_q ? hv_q : verdict_pass);
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_en ? ptr_t'(wr_ptr_q + 1'b1) : wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = m_fire ? ptr_t'(rd_ptr_q + 1'b1) : rd_ptr_q;
        hv_d         = hv_q;
        hvv_d        = hvv_q;
        fd_d         = fd_q;
        pass_cnt_d   = pass_cnt_q;
        drop_cnt_d   = drop_cnt_q;

        // Only the first strobe of a packet is held; later ones are protocol errors.
        if (v_strobe && !hvv_q && state_q != S_END) begin
            hvv_d = 1'b1;
            hv_d  = verdict_pass;
        end

        unique case (state_q)
            S_IDLE: begin
                fd_d = 1'b0;
                if (s_fire) begin
                    state_d = s_axis.tlast ? S_END : S_RECV;
                end
            end

            S_RECV: begin
                if (s_fire && s_axis.tlast) begin
                    state_d = S_END;
                end else if (full && commit_ptr_q == rd_ptr_q) begin
                    // The packet alone fills the buffer and can never complete:
                    // give its space back now and swallow the rest of it.
                    state_d  = S_DISCARD;
                    wr_ptr_d = commit_ptr_q;
                    fd_d     = 1'b1;
                end
            end

            S_DISCARD: begin
                if (s_fire && s_axis.tlast) begin
                    state_d = S_END;
                end
            end

            S_END: begin
                if (end_go) begin
                    if (end_pass) begin
                        commit_ptr_d = wr_ptr_q;
                        pass_cnt_d   = pass_cnt_q + 32'd1;
                    end else begin
                        wr_ptr_d     = commit_ptr_q;
                        drop_cnt_d   = drop_cnt_q + 32'd1;
                    end
                    hvv_d   = 1'b0;
                    fd_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            hv_q         <= 1'b0;
            hvv_q        <= 1'b0;
            fd_q         <= 1'b0;
            pass_cnt_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            hv_q         <= hv_d;
            hvv_q        <= hvv_d;
            fd_q         <= fd_d;
            pass_cnt_q   <= pass_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Storage has no reset: contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge axi_aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= {s_axis.tlast, s_axis.tuser,
                                                s_axis.tstrb, s_axis.tdata};
        end
    end

    assign rd_word = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = rd_word[DW-1:0];
    assign m_axis.tstrb  = rd_word[DW+SW-1:DW];
    assign m_axis.tuser  = rd_word[DW+SW+UW-1:DW+SW];
    assign m_axis.tlast  = rd_word[MW-1];
    assign pass_count    = pass_cnt_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_nf10_pkt_store.sv
// tb/tb_nf10_pkt_store.sv - self-checking bench for nf10_pkt_store
module tb_nf10_pkt_store;
    localparam int DW  = 64;
    localparam int UW  = 16;
    localparam int SW  = DW / 8;
    localparam int DB  = 4;
    localparam int TMO = 400;

    logic        clk = 1'b0;
    logic        rstn;
    logic        verdict_valid;
    logic        verdict_pass;
    logic [31:0] pass_count;
    logic [31:0] drop_count;

    int cyc       = 0;
    int total     = 0;
    int bad       = 0;
    int rise_cnt  = 0;
    int rise_cyc  = 0;
    int out_cnt   = 0;
    int tlast_cyc = 0;
    int strobe_cyc = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        int   n;
        logic pass;
        int   vmode;
        int   vdelay;
        int   exp_pass;
        int   exp_drop;
        int   exp_lat;
    } vec_t;
    vec_t vecs[7];

    nf10_pkt_store_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
    nf10_pkt_store_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    nf10_pkt_store #(
        .C_M_AXIS_DATA_WIDTH (DW),
        .C_M_AXIS_TUSER_WIDTH(UW),
        .DEPTH_BITS          (DB),
        .VERDICT_EN          (1)
    ) dut (
        .axi_aclk     (clk),
        .axi_aresetn  (rstn),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .verdict_valid(verdict_valid),
        .verdict_pass (verdict_pass),
        .pass_count   (pass_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic beat_t mk_beat(input int pid, input int b, input int n);
        beat_t r;
        r.d = {8'(pid), 8'(b), 16'hC0DE, 32'($urandom)};
        r.u = 16'((pid << 8) | b);
        r.s = (b == n - 1) ? 8'h0F : 8'hFF;
        r.l = (b == n - 1);
        return r;
    endfunction

    task automatic monitor_loop();
        logic  prev = 1'b0;
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev = 1'b0;
            end else begin
                if (m_if.tvalid && !prev) begin
                    rise_cnt++;
                    rise_cyc = cyc;
                end
                prev = m_if.tvalid;
                if (m_if.tvalid && m_if.tready) begin
                    out_cnt++;
                    if (sb.size() == 0) begin
                        check("out_unexpected_beat", 64'(m_if.tdata), 64'hDEAD);
                    end else begin
                        e = sb.pop_front();
                        check("out_tdata", 64'(m_if.tdata), 64'(e.d));
                        check("out_tuser", 64'(m_if.tuser), 64'(e.u));
                        check("out_tstrb", 64'(m_if.tstrb), 64'(e.s));
                        check("out_tlast", 64'(m_if.tlast), 64'(e.l));
                    end
                end
            end
        end
    endtask

    // vmode 0: strobe with the first beat; 1: with the second beat; 2: vdelay cycles into END
    task automatic send_pkt(input int pid, input int n, input logic pass,
                            input int vmode, input int vdelay, input bit keep);
        beat_t bt;
        int    guard;
        for (int b = 0; b < n; b++) begin
            bt = mk_beat(pid, b, n);
            @(posedge clk); #1;
            s_if.tvalid   = 1'b1;
            s_if.tdata    = bt.d;
            s_if.tuser    = bt.u;
            s_if.tstrb    = bt.s;
            s_if.tlast    = bt.l;
            verdict_valid = (vmode == 0 && b == 0) || (vmode == 1 && b == 1);
            verdict_pass  = pass;
            @(negedge clk);
            guard = 0;
            while (!s_if.tready && guard < TMO) begin
                @(posedge clk); #1;
                verdict_valid = 1'b0;
                @(negedge clk);
                guard++;
            end
            if (guard >= TMO) check("in_ready_timeout", 64'(guard), 64'(0));
            if (keep) sb.push_back(bt);
            if (b == n - 1) tlast_cyc = cyc;
        end
        @(posedge clk); #1;
        s_if.tvalid   = 1'b0;
        s_if.tlast    = 1'b0;
        verdict_valid = 1'b0;
        if (vmode == 2) begin
            for (int d = 0; d < vdelay; d++) begin
                @(negedge clk);
                check("end_stall_ready", 64'(s_if.tready), 64'(0));
                @(posedge clk); #1;
            end
            verdict_valid = 1'b1;
            verdict_pass  = pass;
            strobe_cyc    = cyc;
            @(posedge clk); #1;
            verdict_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || m_if.tvalid) && guard < TMO) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= TMO) check("drain_timeout", 64'(sb.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int r0;
        int o0;

        vecs[0] = '{3,  1'b1, 1, 0, 1, 0, 2};
        vecs[1] = '{3,  1'b0, 1, 0, 1, 1, -1};
        vecs[2] = '{2,  1'b1, 2, 5, 2, 1, 7};
        vecs[3] = '{1,  1'b1, 0, 0, 3, 1, 2};
        vecs[4] = '{4,  1'b0, 2, 0, 3, 2, -1};
        vecs[5] = '{5,  1'b1, 0, 0, 4, 2, 2};
        vecs[6] = '{16, 1'b1, 1, 0, 5, 2, 2};

        rstn          = 1'b0;
        verdict_valid = 1'b0;
        verdict_pass  = 1'b0;
        s_if.tvalid   = 1'b0;
        s_if.tdata    = '0;
        s_if.tuser    = '0;
        s_if.tstrb    = '0;
        s_if.tlast    = 1'b0;
        m_if.tready   = 1'b1;

        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
        check("rst_pass_count", 64'(pass_count), 64'(0));
        check("rst_drop_count", 64'(drop_count), 64'(0));
        rstn = 1'b1;
        @(negedge clk);
        check("rst_s_tready", 64'(s_if.tready), 64'(1));

        for (int i = 0; i < 7; i++) begin
            r0 = rise_cnt;
            send_pkt(10 + i, vecs[i].n, vecs[i].pass, vecs[i].vmode, vecs[i].vdelay, vecs[i].pass);
            drain();
            check("vec_pass_count", 64'(pass_count), 64'(vecs[i].exp_pass));
            check("vec_drop_count", 64'(drop_count), 64'(vecs[i].exp_drop));
            if (vecs[i].exp_lat < 0)
                check("vec_no_output", 64'(rise_cnt - r0), 64'(0));
            else
                check("vec_latency", 64'(rise_cyc - tlast_cyc), 64'(vecs[i].exp_lat));
            check("vec_idle_ready", 64'(s_if.tready), 64'(1));
        end

        // oversize packet with a pass verdict is still dropped, then a normal packet follows
        r0 = rise_cnt;
        send_pkt(30, 20, 1'b1, 1, 0, 1'b0);
        drain();
        check("over_no_output", 64'(rise_cnt - r0), 64'(0));
        check("over_drop_count", 64'(drop_count), 64'(3));
        check("over_pass_count", 64'(pass_count), 64'(5));
        o0 = out_cnt;
        send_pkt(31, 2, 1'b1, 0, 0, 1'b1);
        drain();
        check("after_over_beats", 64'(out_cnt - o0), 64'(2));
        check("after_over_pass", 64'(pass_count), 64'(6));

        // downstream backpressure fills the buffer across a pointer wrap
        @(posedge clk); #1;
        m_if.tready = 1'b0;
        o0 = out_cnt;
        for (int p = 0; p < 4; p++) send_pkt(40 + p, 4, 1'b1, 0, 0, 1'b1);
        repeat (2) @(negedge clk);
        check("bp_pass_count", 64'(pass_count), 64'(10));
        check("bp_m_tvalid", 64'(m_if.tvalid), 64'(1));
        check("bp_no_beats", 64'(out_cnt - o0), 64'(0));
        fork
            send_pkt(44, 2, 1'b1, 0, 0, 1'b1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_full_stall", 64'(s_if.tready), 64'(0));
                end
                @(posedge clk); #1;
                m_if.tready = 1'b1;
            end
        join
        drain();
        check("bp_beats_out", 64'(out_cnt - o0), 64'(18));
        check("bp_pass_final", 64'(pass_count), 64'(11));

        // reset mid-packet with committed data waiting downstream
        @(posedge clk); #1;
        m_if.tready = 1'b0;
        send_pkt(50, 2, 1'b1, 0, 0, 1'b1);
        repeat (2) @(negedge clk);
        check("pend_m_tvalid", 64'(m_if.tvalid), 64'(1));
        @(posedge clk); #1;
        s_if.tvalid = 1'b1;
        s_if.tlast  = 1'b0;
        s_if.tdata  = 64'h1234;
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        check("async_rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
        check("async_rst_pass", 64'(pass_count), 64'(0));
        check("async_rst_drop", 64'(drop_count), 64'(0));
        sb.delete();
        s_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        m_if.tready = 1'b1;
        @(negedge clk);
        check("post_rst_s_tready", 64'(s_if.tready), 64'(1));
        check("post_rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
        send_pkt(51, 3, 1'b1, 1, 0, 1'b1);
        drain();
        check("post_rst_pass", 64'(pass_count), 64'(1));
        check("post_rst_drop", 64'(drop_count), 64'(0));
        check("post_rst_latency", 64'(rise_cyc - tlast_cyc), 64'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
